// File: rtl/fp_convert_pkg.sv
// rtl/fp_convert_pkg.sv - shared float field layout, classes and classifier for float-to-int conversion
package fp_convert_pkg;

    localparam int FP_EXP_BIAS = 127;
    localparam int FP_MANT_W   = 23;
    localparam int FP_EXP_MAX  = 255;

    typedef struct packed {
        logic                 sign;
        logic [7:0]           exp;
        logic [FP_MANT_W-1:0] frac;
    } fp32_t;

    typedef enum logic [2:0] {
        FP_ZERO,
        FP_TINY,
        FP_NORM,
        FP_BIG,
        FP_INF,
        FP_NAN
    } fp_class_t;

    // Denormals fall into FP_ZERO; FP_TINY covers normals below 0.5.
    function automatic fp_class_t fp_classify(input fp32_t x, input logic [7:0] big_exp);
        if (x.exp == 8'(FP_EXP_MAX)) return (x.frac != '0) ? FP_NAN : FP_INF;
        if (x.exp == 8'd0)           return FP_ZERO;
        if (x.exp < 8'(FP_EXP_BIAS - 1)) return FP_TINY;
        if (x.exp >= big_exp)        return FP_BIG;
        return FP_NORM;
    endfunction

endpackage

// File: rtl/fp_to_int_round_sat.sv
// rtl/fp_to_int_round_sat.sv - combinational round-to-nearest-even, negation and saturation stage
module fp_to_int_round_sat
    import fp_convert_pkg::*;
#(
    parameter int INT_WIDTH = 21,
    parameter int MAG_W     = 24
) (
    input  logic                 sign,
    input  fp_class_t            cls,
    input  logic [MAG_W-1:0]     mag,
    input  logic                 guard,
    input  logic                 sticky,
`ifdef FP_CONVERT_TO_INT_STATUS_EN
    input  logic                 min_exact,
    output logic [2:0]           status,
`endif
    output logic [INT_WIDTH-1:0] result
);

    localparam logic [MAG_W:0]     NEG_LIM = (MAG_W+1)'(1) << (INT_WIDTH - 1);
    localparam logic [MAG_W:0]     POS_LIM = NEG_LIM - (MAG_W+1)'(1);
    localparam logic [INT_WIDTH-1:0] SAT_MAX = {1'b0, {(INT_WIDTH-1){1'b1}}};
    localparam logic [INT_WIDTH-1:0] SAT_MIN = {1'b1, {(INT_WIDTH-1){1'b0}}};

    logic                 round_up;
    logic [MAG_W:0]       rounded;
    logic                 ovf;
    logic [INT_WIDTH-1:0] mag_trunc;

    always_comb begin
        round_up  = guard && (sticky || mag[0]);
        rounded   = {1'b0, mag} + (MAG_W+1)'(round_up);
        // Negative side has one extra code, so -2^(INT_WIDTH-1) is not an overflow.
        ovf       = rounded > (sign ? NEG_LIM : POS_LIM);
        mag_trunc = rounded[INT_WIDTH-1:0];
        case (cls)
            FP_NORM: begin
                if (ovf) result = sign ? SAT_MIN : SAT_MAX;
                else     result = sign ? (INT_WIDTH)'(-mag_trunc) : mag_trunc;
            end
            FP_BIG, FP_INF: result = sign ? SAT_MIN : SAT_MAX;
            default:        result = '0;
        endcase
    end

`ifdef FP_CONVERT_TO_INT_STATUS_EN
    always_comb begin
        status    = 3'b000;
        status[0] = ((cls == FP_NORM) && (guard || sticky)) || (cls == FP_TINY);
        status[1] = (cls == FP_INF) || ((cls == FP_BIG) && !min_exact) || ((cls == FP_NORM) && ovf);
        status[2] = (cls == FP_NAN);
    end
`endif

endmodule

// File: rtl/fp_convert_to_int_pipe.sv
// rtl/fp_convert_to_int_pipe.sv - 3-stage IEEE-754 single to signed integer converter (optional FP_CONVERT_TO_INT_STATUS_EN)
module fp_convert_to_int_pipe
    import fp_convert_pkg::*;
#(
    parameter int INT_WIDTH = 21
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 snk_valid,
    input  logic [31:0]          snk_data,
    output logic                 snk_ready,
    input  logic                 src_ready,
    output logic                 src_valid,
`ifdef FP_CONVERT_TO_INT_STATUS_EN
    output logic [2:0]           src_status,
`endif
    output logic [INT_WIDTH-1:0] src_data
);

    localparam int LATENCY = 3;
    localparam int AW = (INT_WIDTH > 24) ? INT_WIDTH : 24;
    localparam logic [7:0] BIG_EXP   = 8'(FP_EXP_BIAS + INT_WIDTH - 1);
    localparam logic [7:0] ALIGN_EXP = 8'(FP_EXP_BIAS + FP_MANT_W);

    logic [LATENCY-1:0] vld;
    logic               adv;
    fp32_t              in_fp;

    logic               s1_sign;
    fp_class_t          s1_cls;
    logic [7:0]         s1_exp;
    logic [23:0]        s1_mant;

    logic               s2_sign;
    fp_class_t          s2_cls;
    logic [AW-1:0]      s2_mag;
    logic               s2_guard;
    logic               s2_sticky;

    logic [AW+31:0]       wide_in;
    logic [AW+31:0]       wide;
    logic [AW-1:0]        al_mag;
    logic                 al_guard;
    logic                 al_sticky;
    logic [INT_WIDTH-1:0] rs_result;

    assign in_fp     = snk_data;
    assign src_valid = vld[LATENCY-1];
    assign adv       = !src_valid || src_ready;
    assign snk_ready = rst && adv;

    // Mantissa sits above 32 fraction bits so the shifted-out part yields guard and sticky.
    always_comb begin
        wide_in = (AW+32)'({s1_mant, 32'b0});
        if (s1_exp <= ALIGN_EXP) wide = wide_in >> (ALIGN_EXP - s1_exp);
        else                     wide = wide_in << (s1_exp - ALIGN_EXP);
        al_mag    = '0;
        al_guard  = 1'b0;
        al_sticky = 1'b0;
        if (s1_cls == FP_NORM) begin
            al_mag    = wide[AW+31:32];
            al_guard  = wide[31];
            al_sticky = |wide[30:0];
        end
    end

`ifdef FP_CONVERT_TO_INT_STATUS_EN
    logic       s1_min_exact;
    logic       s2_min_exact;
    logic [2:0] rs_status;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_min_exact <= 1'b0;
            s2_min_exact <= 1'b0;
            src_status   <= 3'b000;
        end else if (adv) begin
            s1_min_exact <= in_fp.sign && (in_fp.exp == BIG_EXP) && (in_fp.frac == '0);
            s2_min_exact <= s1_min_exact;
            src_status   <= rs_status;
        end
    end
`endif

    fp_to_int_round_sat #(
        .INT_WIDTH (INT_WIDTH),
        .MAG_W     (AW)
    ) u_round_sat (
        .sign      (s2_sign),
        .cls       (s2_cls),
        .mag       (s2_mag),
        .guard     (s2_guard),
        .sticky    (s2_sticky),
`ifdef FP_CONVERT_TO_INT_STATUS_EN
        .min_exact (s2_min_exact),
        .status    (rs_status),
`endif
        .result    (rs_result)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld       <= '0;
            s1_sign   <= 1'b0;
            s1_cls    <= FP_ZERO;
            s1_exp    <= '0;
            s1_mant   <= '0;
            s2_sign   <= 1'b0;
            s2_cls    <= FP_ZERO;
            s2_mag    <= '0;
            s2_guard  <= 1'b0;
            s2_sticky <= 1'b0;
            src_data  <= '0;
        end else if (adv) begin
            vld       <= {vld[LATENCY-2:0], snk_valid};
            s1_sign   <= in_fp.sign;
            s1_cls    <= fp_classify(in_fp, BIG_EXP);
            s1_exp    <= in_fp.exp;
            s1_mant   <= {1'b1, in_fp.frac};
            s2_sign   <= s1_sign;
            s2_cls    <= s1_cls;
            s2_mag    <= al_mag;
            s2_guard  <= al_guard;
            s2_sticky <= al_sticky;
            src_data  <= rs_result;
        end
    end

endmodule
